// File: rtl/pcie_hcmd_nlb_split.sv
// Purpose     : split a slot's NLB (0-based, from the per-slot table) into DMA chunks of at most P_CHUNK_BLKS blocks; HCMD_NLB_SPLIT_WB_EN enables remaining-count writeback.
// Latency     : first chunk_valid 3 cycles after the command handshake; at least 2 cycles between chunk handshakes.
// Backpressure: chunk outputs hold while chunk_ready is low; writeback waits in S_WB while wr_rdy_n is high; cmd_ready only when idle.
module pcie_hcmd_nlb_split #(
    parameter int P_SLOT_TAG_WIDTH  = 10,
    parameter int P_DATA_WIDTH      = 19,
    parameter int P_CHUNK_BLKS      = 8,
    parameter int P_CHUNK_LEN_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    input  logic [P_SLOT_TAG_WIDTH-1:0]  cmd_slot_tag,
    output logic                         cmd_ready,
    output logic [P_SLOT_TAG_WIDTH-1:0]  rd_addr,
    input  logic [P_DATA_WIDTH-1:0]      rd_data,
    output logic                         wr_en,
    output logic [P_SLOT_TAG_WIDTH-1:0]  wr_addr,
    output logic [P_DATA_WIDTH-1:0]      wr_data,
    input  logic                         wr_rdy_n,
    output logic                         chunk_valid,
    input  logic                         chunk_ready,
    output logic [P_SLOT_TAG_WIDTH-1:0]  chunk_slot_tag,
    output logic [P_CHUNK_LEN_WIDTH-1:0] chunk_len,
    output logic                         chunk_last,
    output logic                         busy
);

    // Remaining count is 1-based, so it needs one extra bit to hold 2^P_DATA_WIDTH.
    localparam int RW = P_DATA_WIDTH + 1;
    localparam logic [RW-1:0]                CHUNK_R = RW'(P_CHUNK_BLKS);
    localparam logic [P_CHUNK_LEN_WIDTH-1:0] CHUNK_L = P_CHUNK_LEN_WIDTH'(P_CHUNK_BLKS);

`ifdef HCMD_NLB_SPLIT_WB_EN
    typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_CAP, S_CHUNK, S_WB} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_CAP, S_CHUNK} state_t;
`endif

    state_t                        state;
    logic [P_SLOT_TAG_WIDTH-1:0]   tag_q;
    logic [RW-1:0]                 remaining;
    logic [RW-1:0]                 rem_cap;
    logic [RW-1:0]                 rem_after;

    function automatic logic [P_CHUNK_LEN_WIDTH-1:0] len_of(input logic [RW-1:0] r);
        if (r > CHUNK_R) len_of = CHUNK_L;
        else             len_of = P_CHUNK_LEN_WIDTH'(r);
    endfunction

    function automatic logic last_of(input logic [RW-1:0] r);
        last_of = (r <= CHUNK_R);
    endfunction

    assign rem_cap        = {1'b0, rd_data} + RW'(1);
    assign rem_after      = remaining - RW'(chunk_len);
    assign rd_addr        = tag_q;
    assign chunk_slot_tag = tag_q;
    assign cmd_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);

`ifdef HCMD_NLB_SPLIT_WB_EN
    logic [P_DATA_WIDTH-1:0] wr_data_q;
    // Strobe is gated by state, so it drops the instant reset forces S_IDLE.
    assign wr_en   = (state == S_WB) && !wr_rdy_n;
    assign wr_addr = tag_q;
    assign wr_data = wr_data_q;
`else
    logic unused_wr_rdy_n;
    assign unused_wr_rdy_n = wr_rdy_n;
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

    // Control FSM: table read, chunk issue, optional writeback of the remaining count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tag_q       <= '0;
            remaining   <= '0;
            chunk_valid <= 1'b0;
            chunk_len   <= '0;
            chunk_last  <= 1'b0;
`ifdef HCMD_NLB_SPLIT_WB_EN
            wr_data_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        tag_q <= cmd_slot_tag;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    remaining   <= rem_cap;
                    chunk_len   <= len_of(rem_cap);
                    chunk_last  <= last_of(rem_cap);
                    chunk_valid <= 1'b1;
                    state       <= S_CHUNK;
                end
                S_CHUNK: begin
                    if (!chunk_valid) begin
                        // Reload cycle after a non-final handshake with no writeback stage.
                        chunk_len   <= len_of(remaining);
                        chunk_last  <= last_of(remaining);
                        chunk_valid <= 1'b1;
                    end else if (chunk_ready) begin
                        remaining   <= rem_after;
                        chunk_valid <= 1'b0;
                        if (chunk_last) begin
                            chunk_last <= 1'b0;
                            state      <= S_IDLE;
                        end
`ifdef HCMD_NLB_SPLIT_WB_EN
                        else begin
                            wr_data_q <= P_DATA_WIDTH'(rem_after - RW'(1));
                            state     <= S_WB;
                        end
`endif
                    end
                end
`ifdef HCMD_NLB_SPLIT_WB_EN
                S_WB: begin
                    if (!wr_rdy_n) begin
                        chunk_len   <= len_of(remaining);
                        chunk_last  <= last_of(remaining);
                        chunk_valid <= 1'b1;
                        state       <= S_CHUNK;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_hcmd_nlb_split.sv
// Purpose     : self-checking bench for pcie_hcmd_nlb_split with an NLB table model and chunk/write scoreboards.
// Latency     : n/a (bench).
// Backpressure: bench drives chunk_ready and wr_rdy_n stalls explicitly.
module tb_pcie_hcmd_nlb_split;

    localparam int TW = 10;
    localparam int DW = 19;
    localparam int CB = 8;
    localparam int LW = 9;

`ifdef HCMD_NLB_SPLIT_WB_EN
    localparam bit WB_ON = 1'b1;
`else
    localparam bit WB_ON = 1'b0;
`endif

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [LW-1:0] len;
        logic          last;
    } chk_t;

    typedef struct packed {
        logic [TW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [TW-1:0] cmd_slot_tag;
    logic          cmd_ready;
    logic [TW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [TW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_rdy_n;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [TW-1:0] chunk_slot_tag;
    logic [LW-1:0] chunk_len;
    logic          chunk_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    chk_t exp_chk[$];
    wr_t  exp_wr[$];
    int   hs_cyc[$];

    // NLB table model: registered read port, one write port plus a bench preload port.
    logic [DW-1:0] tbl [0:(1<<TW)-1];
    logic          pl_en = 1'b0;
    logic [TW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en)      tbl[pl_addr] <= pl_dat;
        else if (wr_en) tbl[wr_addr] <= wr_data;
        rd_data <= tbl[rd_addr];
    end

    pcie_hcmd_nlb_split #(
        .P_SLOT_TAG_WIDTH (TW),
        .P_DATA_WIDTH     (DW),
        .P_CHUNK_BLKS     (CB),
        .P_CHUNK_LEN_WIDTH(LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_slot_tag  (cmd_slot_tag),
        .cmd_ready     (cmd_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_rdy_n      (wr_rdy_n),
        .chunk_valid   (chunk_valid),
        .chunk_ready   (chunk_ready),
        .chunk_slot_tag(chunk_slot_tag),
        .chunk_len     (chunk_len),
        .chunk_last    (chunk_last),
        .busy          (busy)
    );

    // Scoreboard monitor: chunk and write transfers are compared as they occur.
    chk_t          m_exp_c, m_act_c;
    wr_t           m_exp_w, m_act_w;
    bit            stall_prev = 1'b0;
    bit            wr_prev    = 1'b0;
    logic [LW-1:0] p_len;
    logic          p_last;
    logic [TW-1:0] p_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            wr_prev    = 1'b0;
        end else begin
            cyc++;
            if (stall_prev) begin
                checks++;
                if (chunk_valid !== 1'b1 || chunk_len !== p_len || chunk_last !== p_last || chunk_slot_tag !== p_tag) begin
                    failures++;
                    $display("FAIL stall_hold got v=%0b len=%0d last=%0b tag=%0h exp v=1 len=%0d last=%0b tag=%0h",
                             chunk_valid, chunk_len, chunk_last, chunk_slot_tag, p_len, p_last, p_tag);
                end
            end
            if (chunk_valid && chunk_ready) begin
                m_act_c.tag  = chunk_slot_tag;
                m_act_c.len  = chunk_len;
                m_act_c.last = chunk_last;
                checks++;
                if (exp_chk.size() == 0) begin
                    failures++;
                    $display("FAIL chunk_unexpected got tag=%0h len=%0d last=%0b exp none",
                             m_act_c.tag, m_act_c.len, m_act_c.last);
                end else begin
                    m_exp_c = exp_chk.pop_front();
                    if (m_act_c !== m_exp_c) begin
                        failures++;
                        $display("FAIL chunk got tag=%0h len=%0d last=%0b exp tag=%0h len=%0d last=%0b",
                                 m_act_c.tag, m_act_c.len, m_act_c.last, m_exp_c.tag, m_exp_c.len, m_exp_c.last);
                    end
                end
                hs_cyc.push_back(cyc);
            end
            stall_prev = chunk_valid && !chunk_ready;
            p_len  = chunk_len;
            p_last = chunk_last;
            p_tag  = chunk_slot_tag;
            if (wr_en) begin
                m_act_w.addr = wr_addr;
                m_act_w.dat  = wr_data;
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got addr=%0h data=%0d exp none", wr_addr, wr_data);
                end else begin
                    m_exp_w = exp_wr.pop_front();
                    if (m_act_w !== m_exp_w || wr_prev || chunk_valid || wr_rdy_n) begin
                        failures++;
                        $display("FAIL write got addr=%0h data=%0d prev=%0b cv=%0b rdy_n=%0b exp addr=%0h data=%0d single pulse",
                                 wr_addr, wr_data, wr_prev, chunk_valid, wr_rdy_n, m_exp_w.addr, m_exp_w.dat);
                    end
                end
            end
            wr_prev = wr_en;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Reference model: expected chunks and writebacks for one command.
    task automatic push_expect(input logic [TW-1:0] tag, input logic [DW-1:0] nlb);
        logic [DW:0] rem;
        chk_t c;
        wr_t  w;
        rem = {1'b0, nlb} + 20'd1;
        while (rem != 0) begin
            c.tag  = tag;
            c.last = (rem <= 20'd8);
            c.len  = c.last ? rem[LW-1:0] : 9'd8;
            exp_chk.push_back(c);
            rem = rem - {11'd0, c.len};
            if (WB_ON && !c.last) begin
                w.addr = tag;
                w.dat  = rem[DW-1:0] - 19'd1;
                exp_wr.push_back(w);
            end
        end
    endtask

    task automatic preload(input logic [TW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue_cmd(input logic [TW-1:0] tag, output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_slot_tag = tag;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ok) begin
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (chunk_valid) begin lat = n; break; end
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (cmd_ready && exp_chk.size() == 0 && exp_wr.size() == 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || chunk_valid !== 1'b0 || wr_en !== 1'b0 || chunk_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%0b busy=%0b cv=%0b we=%0b last=%0b exp 1 0 0 0 0",
                     cmd_ready, busy, chunk_valid, wr_en, chunk_last);
        end
        checks++;
        if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 || chunk_slot_tag !== '0 || chunk_len !== '0) begin
            failures++;
            $display("FAIL reset_data got rd=%0h wa=%0h wd=%0h tag=%0h len=%0d exp all 0",
                     rd_addr, wr_addr, wr_data, chunk_slot_tag, chunk_len);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || chunk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%0b busy=%0b cv=%0b exp 1 0 0", cmd_ready, busy, chunk_valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit ok, done;
        chunk_ready = 1'b1; wr_rdy_n = 1'b0;
        preload(10'h005, 19'd19);
        hs_cyc.delete();
        push_expect(10'h005, 19'd19);
        issue_cmd(10'h005, lat, ok);
        checks++;
        if (!ok || lat != 3) begin
            failures++;
            $display("FAIL basic_latency got ok=%0b lat=%0d exp ok=1 lat=3", ok, lat);
        end
        wait_done(200, done);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL basic_done got chunks_left=%0d writes_left=%0d exp 0 0", exp_chk.size(), exp_wr.size());
        end
        checks++;
        if (hs_cyc.size() != 3) begin
            failures++;
            $display("FAIL basic_chunk_count got %0d exp 3", hs_cyc.size());
        end else if (hs_cyc[1] - hs_cyc[0] != 2 || hs_cyc[2] - hs_cyc[1] != 2) begin
            failures++;
            $display("FAIL basic_gap got %0d,%0d exp 2,2", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
        end
        checks++;
        if (tbl[10'h005] !== (WB_ON ? 19'd3 : 19'd19)) begin
            failures++;
            $display("FAIL basic_table got %0d exp %0d", tbl[10'h005], WB_ON ? 3 : 19);
        end
    endtask

    task automatic test_single();
        int lat;
        bit ok, done;
        logic [DW-1:0] nlbs [2];
        nlbs[0] = 19'd0;
        nlbs[1] = 19'd7;
        for (int i = 0; i < 2; i++) begin
            preload(10'h010 + 10'(i), nlbs[i]);
            hs_cyc.delete();
            push_expect(10'h010 + 10'(i), nlbs[i]);
            issue_cmd(10'h010 + 10'(i), lat, ok);
            wait_done(100, done);
            checks++;
            if (!ok || lat != 3 || !done || hs_cyc.size() != 1) begin
                failures++;
                $display("FAIL single_%0d got ok=%0b lat=%0d done=%0b chunks=%0d exp 1 3 1 1",
                         i, ok, lat, done, hs_cyc.size());
            end
            checks++;
            if (tbl[10'h010 + 10'(i)] !== nlbs[i]) begin
                failures++;
                $display("FAIL single_table_%0d got %0d exp %0d", i, tbl[10'h010 + 10'(i)], nlbs[i]);
            end
        end
    endtask

    task automatic test_max();
        int lat;
        bit ok;
        chk_t c;
        wr_t  w;
        chunk_ready = 1'b1; wr_rdy_n = 1'b0;
        preload(10'h3FF, 19'h7FFFF);
        c.tag = 10'h3FF; c.len = 9'd8; c.last = 1'b0;
        exp_chk.push_back(c);
        if (WB_ON) begin
            w.addr = 10'h3FF; w.dat = 19'd524279;
            exp_wr.push_back(w);
        end
        issue_cmd(10'h3FF, lat, ok);
        @(posedge clk); #1;
        chunk_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || chunk_valid !== 1'b1 || chunk_len !== 9'd8 || chunk_last !== 1'b0) begin
            failures++;
            $display("FAIL max_second_chunk got ok=%0b cv=%0b len=%0d last=%0b exp 1 1 8 0",
                     ok, chunk_valid, chunk_len, chunk_last);
        end
        checks++;
        if (exp_chk.size() != 0 || exp_wr.size() != 0) begin
            failures++;
            $display("FAIL max_pending got chunks=%0d writes=%0d exp 0 0", exp_chk.size(), exp_wr.size());
        end
        checks++;
        if (tbl[10'h3FF] !== (WB_ON ? 19'd524279 : 19'h7FFFF)) begin
            failures++;
            $display("FAIL max_table got %0d exp %0d", tbl[10'h3FF], WB_ON ? 524279 : 19'h7FFFF);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chunk_ready = 1'b1;
    endtask

    task automatic test_stall();
        int lat;
        bit ok, done, seen;
        chunk_ready = 1'b1; wr_rdy_n = 1'b0;
        preload(10'h022, 19'd19);
        push_expect(10'h022, 19'd19);
        issue_cmd(10'h022, lat, ok);
        @(posedge clk); #1;
        chunk_ready = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (chunk_valid) begin seen = 1'b1; break; end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (!seen || chunk_valid !== 1'b1 || chunk_len !== 9'd8 || chunk_last !== 1'b0 || chunk_slot_tag !== 10'h022) begin
                failures++;
                $display("FAIL stall_chunk2_%0d got cv=%0b len=%0d last=%0b tag=%0h exp 1 8 0 22",
                         i, chunk_valid, chunk_len, chunk_last, chunk_slot_tag);
            end
        end
        @(posedge clk); #1;
        chunk_ready = 1'b1;
        wr_rdy_n    = 1'b1;
        @(posedge clk); #1;
`ifdef HCMD_NLB_SPLIT_WB_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || chunk_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL wb_hold_%0d got we=%0b cv=%0b busy=%0b exp 0 0 1", i, wr_en, chunk_valid, busy);
            end
            if (i < 2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        wr_rdy_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || chunk_valid !== 1'b0) begin
            failures++;
            $display("FAIL wb_release got we=%0b cv=%0b exp 1 0", wr_en, chunk_valid);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || chunk_valid !== 1'b1 || chunk_len !== 9'd4 || chunk_last !== 1'b1) begin
            failures++;
            $display("FAIL wb_after got we=%0b cv=%0b len=%0d last=%0b exp 0 1 4 1", wr_en, chunk_valid, chunk_len, chunk_last);
        end
`else
        @(negedge clk);
        checks++;
        if (chunk_valid !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL nowb_gap got cv=%0b we=%0b exp 0 0", chunk_valid, wr_en);
        end
        @(negedge clk);
        checks++;
        if (chunk_valid !== 1'b1 || chunk_len !== 9'd4 || chunk_last !== 1'b1) begin
            failures++;
            $display("FAIL nowb_next got cv=%0b len=%0d last=%0b exp 1 4 1", chunk_valid, chunk_len, chunk_last);
        end
        wr_rdy_n = 1'b0;
`endif
        wait_done(100, done);
        checks++;
        if (!ok || !done || tbl[10'h022] !== (WB_ON ? 19'd3 : 19'd19)) begin
            failures++;
            $display("FAIL stall_done got ok=%0b done=%0b table=%0d exp 1 1 %0d", ok, done, tbl[10'h022], WB_ON ? 3 : 19);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok, done;
        chunk_ready = 1'b1; wr_rdy_n = 1'b1;
        preload(10'h030, 19'd19);
        preload(10'h031, 19'd2);
        push_expect(10'h030, 19'd19);
        issue_cmd(10'h030, lat, ok);
        @(posedge clk); #1;
        chunk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_pre_%0d got we=%0b busy=%0b exp 0 1", i, wr_en, busy);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || chunk_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_reset got we=%0b cv=%0b rdy=%0b busy=%0b exp 0 0 1 0", wr_en, chunk_valid, cmd_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_chk.delete();
        exp_wr.delete();
        wr_rdy_n = 1'b0; chunk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || tbl[10'h030] !== 19'd19) begin
            failures++;
            $display("FAIL rstmid_after got rdy=%0b table=%0d exp 1 19", cmd_ready, tbl[10'h030]);
        end
        hs_cyc.delete();
        push_expect(10'h031, 19'd2);
        issue_cmd(10'h031, lat, ok);
        wait_done(100, done);
        checks++;
        if (!ok || lat != 3 || !done || hs_cyc.size() != 1) begin
            failures++;
            $display("FAIL rstmid_fresh got ok=%0b lat=%0d done=%0b chunks=%0d exp 1 3 1 1", ok, lat, done, hs_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, done;
        chunk_ready = 1'b1; wr_rdy_n = 1'b0;
        preload(10'h040, 19'd10);
        preload(10'h041, 19'd3);
        hs_cyc.delete();
        push_expect(10'h040, 19'd10);
        push_expect(10'h041, 19'd3);
        ok1 = 1'b0; ok2 = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_slot_tag = 10'h040;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok1 = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_slot_tag = 10'h041;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ignore got rdy=%0b busy=%0b exp 0 1", cmd_ready, busy);
        end
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok2 = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(100, done);
        checks++;
        if (!ok1 || !ok2 || !done || hs_cyc.size() != 3) begin
            failures++;
            $display("FAIL b2b_done got ok1=%0b ok2=%0b done=%0b chunks=%0d exp 1 1 1 3", ok1, ok2, done, hs_cyc.size());
        end else if (hs_cyc[1] - hs_cyc[0] != 2) begin
            failures++;
            $display("FAIL b2b_gap got %0d exp 2", hs_cyc[1] - hs_cyc[0]);
        end
        checks++;
        if (tbl[10'h040] !== (WB_ON ? 19'd2 : 19'd10) || tbl[10'h041] !== 19'd3) begin
            failures++;
            $display("FAIL b2b_table got %0d,%0d exp %0d,3", tbl[10'h040], tbl[10'h041], WB_ON ? 2 : 10);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_slot_tag = '0;
        wr_rdy_n     = 1'b0;
        chunk_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_single();
        test_max();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
